controle_recepcao_serial: RTL and testbench
===========================================

// Module: controle_recepcao_serial
// PURPOSE
//  Receives 8N1 ASCII commands on RX and holds the runtime configuration of the tank monitor.
//  Outputs: level thresholds nv_crit/nv_alto/nv_baixo (3 BCD digits, same nibble format as distancia),
//  the manual-mode flag and the manual valve request. Feeds classificador_medida (thresholds) and valvula (manual, abrir_valv).
// PARAMETERS
//  CICLOS_BIT     434       clock cycles per serial bit (50 MHz / 115200)
//  TIMEOUT        5000000   max cycles between bytes of one command before abort (100 ms)
//  NV_CRIT_INI    12'h005   nv_crit reset value (BCD)
//  NV_ALTO_INI    12'h010   nv_alto reset value (BCD)
//  NV_BAIXO_INI   12'h050   nv_baixo reset value (BCD)
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low; 0 clears all state
//  RX          in   1   serial input, idle high, 8N1, LSB first
//  nv_crit     out  12  critical-level threshold, BCD [11:8]=hundreds [7:4]=tens [3:0]=units
//  nv_alto     out  12  high-level threshold, BCD
//  nv_baixo    out  12  low-level threshold, BCD
//  manual      out  1   1 = valve under serial control, 0 = automatic
//  abrir_valv  out  1   manual valve request (1 = open); meaningful only while manual=1
//  cmd_ok      out  1   one-cycle pulse when a command is committed
//  erro_cmd    out  1   one-cycle pulse on invalid byte, framing error or timeout
//  db_estado   out  4   parser state code, debug
// BEHAVIOUR
//  Reset (reset=0): thresholds = *_INI, manual=0, abrir_valv=0, cmd_ok=erro_cmd=0, both FSMs idle.
//  Reset mid-byte or mid-command discards everything. No partial update.
//  RX path:
//  - RX passes through a 2-FF synchronizer, reset to 1.
//  - IDLE: on sync RX=0, go to START and wait CICLOS_BIT/2.
//  - Still 0 at START end: accept and go to DADOS. If 1: false start, back to IDLE, no error.
//  - DADOS: sample 8 bits every CICLOS_BIT, LSB first.
//  - STOP: sample once. 1 gives a one-cycle byte_valido. 0 is a framing error: erro_cmd pulse, byte dropped, parser reset to ESPERA.
//  - Return to IDLE right after the stop sample. Back-to-back bytes must be accepted.
//  Parser FSM (db_estado code):
//   ESPERA(0) -> D1(1) -> D2(2) -> D3(3) -> ESPERA.
//  - In ESPERA, on byte_valido:
//    - 'C' 0x43, 'A' 0x41, 'B' 0x42: latch target, go to D1.
//    - 'M' 0x4D: manual=1, cmd_ok.
//    - 'U' 0x55: manual=0 and abrir_valv=0, cmd_ok.
//    - 'O' 0x4F: abrir_valv=1 and cmd_ok if manual=1. If manual=0: erro_cmd, no change.
//    - 'F' 0x46: abrir_valv=0, cmd_ok (any mode).
//    - CR 0x0D, LF 0x0A: ignored silently.
//    - Any other byte: erro_cmd.
//  - D1/D2/D3: byte must be '0'..'9' (0x30..0x39). Store byte-0x30 into hundreds, tens, units.
//    - Non-digit: erro_cmd, go to ESPERA, target unchanged.
//  - On a valid D3 digit, in the same cycle: write all 12 bits of the target register atomically, pulse cmd_ok, go to ESPERA.
//  - Timeout counter clears on every byte_valido and counts only in D1..D3.
//    - At TIMEOUT it aborts to ESPERA with erro_cmd, target unchanged.
//  No ordering check between thresholds; that is the host's responsibility.
//  All outputs are registered. Threshold/flag updates appear the cycle after byte_valido.
//  cmd_ok and erro_cmd are never asserted in the same cycle.
// TESTING
//  Use CICLOS_BIT=8 and TIMEOUT=200 in sim.
//  1. Reset release -> nv_crit=005, nv_alto=010, nv_baixo=050 (hex), manual=0, abrir_valv=0, db_estado=0.
//  2. Send "C","0","2","7" -> nv_crit=12'h027 one cycle after the 4th byte, single cmd_ok. Other thresholds unchanged.
//     nv_crit must stay 005 after each of the first three bytes.
//  3. Send "B","1","x" -> erro_cmd on 'x', nv_baixo still 050, db_estado=0.
//     Then "B","1","2","0" -> nv_baixo=12'h120.
//  4. "O" with manual=0 -> erro_cmd, abrir_valv=0.
//     Then "M","O" -> manual=1, abrir_valv=1.
//     Then "U" -> manual=0, abrir_valv=0.
//  5. "A","3" then idle 200 cycles -> erro_cmd, nv_alto=010.
//     Also: byte with stop bit 0 -> erro_cmd, no update.
//     Also: 2-cycle RX glitch -> no byte, no error.
//  6. Assert reset during D2 of "A","4","5","6" -> nv_alto=010 and parser in ESPERA after release.
//     A fresh "A456" is then accepted.

Source files
------------

// File: rtl/controle_recepcao_serial.sv
// Serial command receiver for the tank monitor: 8N1 UART receiver feeding a
// small ASCII command parser that owns the level thresholds and valve mode.
module controle_recepcao_serial #(
  parameter int          CICLOS_BIT   = 434,
  parameter int          TIMEOUT      = 5000000,
  parameter logic [11:0] NV_CRIT_INI  = 12'h005,
  parameter logic [11:0] NV_ALTO_INI  = 12'h010,
  parameter logic [11:0] NV_BAIXO_INI = 12'h050
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic [11:0] nv_crit,
  output logic [11:0] nv_alto,
  output logic [11:0] nv_baixo,
  output logic        manual,
  output logic        abrir_valv,
  output logic        cmd_ok,
  output logic        erro_cmd,
  output logic [3:0]  db_estado
);

  localparam int CW = (CICLOS_BIT > 2) ? $clog2(CICLOS_BIT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MEIO  = CW'(CICLOS_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT   = CW'(CICLOS_BIT - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DADOS, R_STOP} rx_est_t;
  typedef enum logic [1:0] {ESPERA = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} par_est_t;
  typedef enum logic [1:0] {T_CRIT, T_ALTO, T_BAIXO} alvo_t;

  logic          rx_s1, rx_s2;
  rx_est_t       rx_est, rx_est_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          byte_valido, erro_quadro;

  par_est_t      p_est, p_est_n;
  alvo_t         alvo, alvo_n;
  logic [3:0]    cent, cent_n, dez, dez_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [11:0]   crit_n, alto_n, baixo_n;
  logic          man_n, abr_n, ok_n, err_n;
  logic          eh_digito;

  // Two-flop synchronizer on the asynchronous serial line (idles high)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
    end
  end

  // Receiver state and bit-timing registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_est  <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_est  <= rx_est_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  // Receiver next state: mid-bit sampling, LSB first; stop bit decides valid/framing error
  always_comb begin
    rx_est_n    = rx_est;
    cnt_n       = cnt + 1'b1;
    bit_n       = bit_idx;
    shift_n     = shift;
    byte_valido = 1'b0;
    erro_quadro = 1'b0;
    unique case (rx_est)
      R_IDLE: begin
        cnt_n = '0;
        if (!rx_s2) rx_est_n = R_START;
      end
      R_START: if (cnt == CNT_MEIO) begin
        cnt_n    = '0;
        bit_n    = '0;
        rx_est_n = rx_s2 ? R_IDLE : R_DADOS;
      end
      R_DADOS: if (cnt == CNT_BIT) begin
        cnt_n   = '0;
        shift_n = {rx_s2, shift[7:1]};
        bit_n   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) rx_est_n = R_STOP;
      end
      R_STOP: if (cnt == CNT_BIT) begin
        cnt_n    = '0;
        rx_est_n = R_IDLE;
        if (rx_s2) byte_valido = 1'b1;
        else       erro_quadro = 1'b1;
      end
      default: rx_est_n = R_IDLE;
    endcase
  end

  assign eh_digito = (shift >= 8'h30) && (shift <= 8'h39);
  assign db_estado = {2'b00, p_est};

  // Parser registers and all registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_est      <= ESPERA;
      alvo       <= T_CRIT;
      cent       <= '0;
      dez        <= '0;
      tmo        <= '0;
      nv_crit    <= NV_CRIT_INI;
      nv_alto    <= NV_ALTO_INI;
      nv_baixo   <= NV_BAIXO_INI;
      manual     <= 1'b0;
      abrir_valv <= 1'b0;
      cmd_ok     <= 1'b0;
      erro_cmd   <= 1'b0;
    end else begin
      p_est      <= p_est_n;
      alvo       <= alvo_n;
      cent       <= cent_n;
      dez        <= dez_n;
      tmo        <= tmo_n;
      nv_crit    <= crit_n;
      nv_alto    <= alto_n;
      nv_baixo   <= baixo_n;
      manual     <= man_n;
      abrir_valv <= abr_n;
      cmd_ok     <= ok_n;
      erro_cmd   <= err_n;
    end
  end

  // Parser next state; digits are buffered and the threshold is written only on the last one
  always_comb begin
    p_est_n = p_est;
    alvo_n  = alvo;
    cent_n  = cent;
    dez_n   = dez;
    crit_n  = nv_crit;
    alto_n  = nv_alto;
    baixo_n = nv_baixo;
    man_n   = manual;
    abr_n   = abrir_valv;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    tmo_n   = (p_est == ESPERA) ? '0 : tmo + 1'b1;
    if (byte_valido) tmo_n = '0;

    if (erro_quadro) begin
      err_n   = 1'b1;
      p_est_n = ESPERA;
    end else if (byte_valido) begin
      unique case (p_est)
        ESPERA: begin
          case (shift)
            8'h43: begin alvo_n = T_CRIT;  p_est_n = D1; end
            8'h41: begin alvo_n = T_ALTO;  p_est_n = D1; end
            8'h42: begin alvo_n = T_BAIXO; p_est_n = D1; end
            8'h4D: begin man_n = 1'b1; ok_n = 1'b1; end
            8'h55: begin man_n = 1'b0; abr_n = 1'b0; ok_n = 1'b1; end
            8'h4F: begin
              if (manual) begin abr_n = 1'b1; ok_n = 1'b1; end
              else        err_n = 1'b1;
            end
            8'h46: begin abr_n = 1'b0; ok_n = 1'b1; end
            8'h0D, 8'h0A: ;
            default: err_n = 1'b1;
          endcase
        end
        D1, D2, D3: begin
          if (!eh_digito) begin
            err_n   = 1'b1;
            p_est_n = ESPERA;
          end else if (p_est == D1) begin
            cent_n  = shift[3:0];
            p_est_n = D2;
          end else if (p_est == D2) begin
            dez_n   = shift[3:0];
            p_est_n = D3;
          end else begin
            unique case (alvo)
              T_CRIT:  crit_n  = {cent, dez, shift[3:0]};
              T_ALTO:  alto_n  = {cent, dez, shift[3:0]};
              default: baixo_n = {cent, dez, shift[3:0]};
            endcase
            ok_n    = 1'b1;
            p_est_n = ESPERA;
          end
        end
        default: p_est_n = ESPERA;
      endcase
    end else if ((p_est != ESPERA) && (tmo == TMO_LIMIT)) begin
      err_n   = 1'b1;
      p_est_n = ESPERA;
    end
  end

endmodule

// File: tb/tb_controle_recepcao_serial.sv
// Directed bench for controle_recepcao_serial with a scoreboard of expected
// command events (cmd_ok / erro_cmd) and the output state they must leave.
module tb_controle_recepcao_serial;

  localparam int CB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] nv_crit, nv_alto, nv_baixo;
  logic        manual, abrir_valv, cmd_ok, erro_cmd;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_errors = 0;
  int n_events = 0;

  typedef struct {
    logic        ok;
    logic [11:0] crit, alto, baixo;
    logic        man, abr;
    string       tag;
  } evento_t;

  evento_t sb[$];

  controle_recepcao_serial #(.CICLOS_BIT(CB), .TIMEOUT(200)) dut (
    .clock(clock), .reset(reset), .RX(RX),
    .nv_crit(nv_crit), .nv_alto(nv_alto), .nv_baixo(nv_baixo),
    .manual(manual), .abrir_valv(abrir_valv),
    .cmd_ok(cmd_ok), .erro_cmd(erro_cmd), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic ok, input logic [11:0] crit, input logic [11:0] alto,
                           input logic [11:0] baixo, input logic man, input logic abr,
                           input string tag);
    evento_t e;
    e.ok = ok; e.crit = crit; e.alto = alto; e.baixo = baixo;
    e.man = man; e.abr = abr; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clock);
    RX = 1'b0;
    repeat (CB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CB) @(posedge clock);
    end
    RX = stop_bit;
    repeat (CB) @(posedge clock);
    RX = 1'b1;
    repeat (6) @(posedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every command pulse must match the oldest expectation
  always @(negedge clock) begin
    if (reset && (cmd_ok || erro_cmd)) begin
      evento_t e;
      n_events++;
      chk("pulses_exclusive", {31'b0, cmd_ok & erro_cmd}, 32'd0);
      n_checks++;
      assert (sb.size() > 0) else begin
        n_errors++;
        $error("FAIL unexpected_event: observed ok=%0b err=%0b expected no event", cmd_ok, erro_cmd);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, "_cmd_ok"},   {31'b0, cmd_ok},   {31'b0, e.ok});
        chk({e.tag, "_erro_cmd"}, {31'b0, erro_cmd}, {31'b0, ~e.ok});
        chk({e.tag, "_nv_crit"},  {20'b0, nv_crit},  {20'b0, e.crit});
        chk({e.tag, "_nv_alto"},  {20'b0, nv_alto},  {20'b0, e.alto});
        chk({e.tag, "_nv_baixo"}, {20'b0, nv_baixo}, {20'b0, e.baixo});
        chk({e.tag, "_manual"},   {31'b0, manual},   {31'b0, e.man});
        chk({e.tag, "_abrir"},    {31'b0, abrir_valv}, {31'b0, e.abr});
      end
    end
  end

  initial begin
    int ev0;
    // 1. reset values
    idle(3);
    reset = 1'b1;
    idle(3);
    chk("rst_nv_crit",  {20'b0, nv_crit},  32'h005);
    chk("rst_nv_alto",  {20'b0, nv_alto},  32'h010);
    chk("rst_nv_baixo", {20'b0, nv_baixo}, 32'h050);
    chk("rst_manual",   {31'b0, manual},   32'd0);
    chk("rst_abrir",    {31'b0, abrir_valv}, 32'd0);
    chk("rst_estado",   {28'b0, db_estado}, 32'd0);

    // 2. C027
    send_byte(8'h43, 1'b1); #1;
    chk("c027_crit_after_C", {20'b0, nv_crit}, 32'h005);
    chk("c027_estado_D1", {28'b0, db_estado}, 32'd1);
    send_byte(8'h30, 1'b1); #1;
    chk("c027_crit_after_0", {20'b0, nv_crit}, 32'h005);
    chk("c027_estado_D2", {28'b0, db_estado}, 32'd2);
    send_byte(8'h32, 1'b1); #1;
    chk("c027_crit_after_2", {20'b0, nv_crit}, 32'h005);
    chk("c027_estado_D3", {28'b0, db_estado}, 32'd3);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h050, 1'b0, 1'b0, "c027");
    send_byte(8'h37, 1'b1); #1;
    chk("c027_estado_back", {28'b0, db_estado}, 32'd0);

    // 3. B1x rejected, then B120
    send_byte(8'h42, 1'b1);
    send_byte(8'h31, 1'b1);
    expect_ev(1'b0, 12'h027, 12'h010, 12'h050, 1'b0, 1'b0, "b1x");
    send_byte(8'h78, 1'b1); #1;
    chk("b1x_estado", {28'b0, db_estado}, 32'd0);
    chk("b1x_baixo", {20'b0, nv_baixo}, 32'h050);
    send_byte(8'h42, 1'b1);
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h120, 1'b0, 1'b0, "b120");
    send_byte(8'h30, 1'b1);

    // 4. valve commands
    expect_ev(1'b0, 12'h027, 12'h010, 12'h120, 1'b0, 1'b0, "o_auto");
    send_byte(8'h4F, 1'b1);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h120, 1'b1, 1'b0, "m");
    send_byte(8'h4D, 1'b1);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h120, 1'b1, 1'b1, "o_man");
    send_byte(8'h4F, 1'b1);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h120, 1'b1, 1'b0, "f");
    send_byte(8'h46, 1'b1);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h120, 1'b1, 1'b1, "o_man2");
    send_byte(8'h4F, 1'b1);
    expect_ev(1'b1, 12'h027, 12'h010, 12'h120, 1'b0, 1'b0, "u");
    send_byte(8'h55, 1'b1);

    // CR/LF ignored silently
    ev0 = n_events;
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1); #1;
    chk("crlf_no_event", n_events - ev0, 32'd0);

    // 5. timeout in D2
    send_byte(8'h41, 1'b1);
    expect_ev(1'b0, 12'h027, 12'h010, 12'h120, 1'b0, 1'b0, "timeout");
    send_byte(8'h33, 1'b1);
    idle(260);
    chk("timeout_alto", {20'b0, nv_alto}, 32'h010);
    chk("timeout_estado", {28'b0, db_estado}, 32'd0);
    chk("timeout_seen", sb.size(), 32'd0);

    // framing error mid-command: no update
    send_byte(8'h43, 1'b1);
    expect_ev(1'b0, 12'h027, 12'h010, 12'h120, 1'b0, 1'b0, "frame");
    send_byte(8'h39, 1'b0);
    idle(20);
    chk("frame_crit", {20'b0, nv_crit}, 32'h027);
    chk("frame_estado", {28'b0, db_estado}, 32'd0);

    // 2-cycle glitch: nothing happens
    ev0 = n_events;
    @(posedge clock); RX = 1'b0;
    repeat (2) @(posedge clock); RX = 1'b1;
    idle(40);
    chk("glitch_no_event", n_events - ev0, 32'd0);
    chk("glitch_estado", {28'b0, db_estado}, 32'd0);

    // 6. reset during D2 of A456
    send_byte(8'h41, 1'b1);
    send_byte(8'h34, 1'b1);
    @(posedge clock); RX = 1'b0;
    repeat (3 * CB) @(posedge clock);
    reset = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(3 * CB);
    chk("rstmid_alto", {20'b0, nv_alto}, 32'h010);
    chk("rstmid_crit", {20'b0, nv_crit}, 32'h005);
    chk("rstmid_estado", {28'b0, db_estado}, 32'd0);
    send_byte(8'h41, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h35, 1'b1);
    expect_ev(1'b1, 12'h005, 12'h456, 12'h050, 1'b0, 1'b0, "a456");
    send_byte(8'h36, 1'b1);
    idle(10);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
